seg7_scan_capture: RTL and testbench
====================================

Name: seg7_scan_capture

Overview:
- Receive side of the multiplexed 7-segment display interface: samples a segment bus plus one-hot digit-select strobe and recovers the BCD value of each digit.
- Segment bit order matches the team's BCD-to-7-seg driver: bit6..bit0 = a,b,c,d,e,f,g, active-high (digit 0 = 7'b1111110).
- Used for loopback self-test of the display path and for reading external display boards back into the FPGA.

Parameters:
- NUM_DIG, 4, number of multiplexed digits, 1..8.
- STABLE_CYC, 4, consecutive identical samples required before a digit is accepted, 1..255.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous reset, active-low.
- seg_in  input  7  segment bus {a,b,c,d,e,f,g}.
- dig_sel  input  NUM_DIG  digit strobe, active-high, one-hot when valid.
- bcd_out  output  4*NUM_DIG  captured digits, digit k in bits [4k+3:4k].
- dig_valid  output  NUM_DIG  bit k set once digit k has been captured since the last frame_done.
- frame_done  output  1  one-cycle pulse when all dig_valid bits become set.
- pat_err  output  1  sticky: set by any accepted pattern outside the 0-9 table.

Behaviour:
- Reset: on a clk edge with rst_n=0, bcd_out=0, dig_valid=0, frame_done=0, pat_err=0, FSM=IDLE, stability counter=0. Reset asserted mid-operation discards any partial capture.
- Inputs are registered once (sample stage). All comparisons below use the registered values, giving 1 cycle of input latency.
- Select is valid only when exactly one dig_sel bit is set. Zero or multiple bits count as invalid.
- FSM states:
  - IDLE: wait for a valid select. Next cycle goes to SETTLE; latch seg/sel as reference; cnt=1.
  - SETTLE: if sel and seg equal the reference, cnt++. Otherwise reload the reference with the current sample and cnt=1, or go to IDLE if the select is invalid. When cnt reaches STABLE_CYC, go to CAPTURE.
  - CAPTURE (1 cycle): decode the reference pattern and write digit k; set dig_valid[k]; go to HOLD.
  - HOLD: stay while sel and seg are unchanged. Any change goes to SETTLE with the reference reloaded, or to IDLE if the select is invalid.
- With STABLE_CYC=1, CAPTURE follows the first SETTLE cycle.
- Decode: the 10 canonical patterns map to 0-9. Any other pattern writes 4'hF and sets pat_err.
- Capture latency: a stable pattern present from cycle t is written to bcd_out at the end of cycle t+1+STABLE_CYC.
- Re-capturing an already-valid digit overwrites its value. dig_valid is unaffected.
- Frame completion:
  - The cycle dig_valid becomes all-ones, frame_done=1 for exactly 1 cycle.
  - On the following cycle dig_valid clears to 0. bcd_out retains its values.
  - If a capture coincides with the clear cycle, its dig_valid bit is set; the clear does not mask it.
- pat_err clears only on reset.
- Glitch shorter than STABLE_CYC samples: no capture and no error, only a counter restart.

Optional Feature:
- Macro: SEG7_BLANK_DECODE_EN.
- Defined: pattern 7'b0000000 decodes to 4'hA (blank digit) without setting pat_err.
- Undefined: an all-zero pattern is treated as invalid, writing 4'hF and setting pat_err.

Test Plan:
- Reset, then hold dig_sel=4'b0001, seg_in=7'b0110000 for 10 cycles -> bcd_out[3:0]=1 at cycle 1+4 after first sample; dig_valid=4'b0001; pat_err=0.
- Scan digits 0..3 with patterns for 2,0,2,5, each held 6 cycles -> bcd_out=16'h5202; frame_done pulses once; dig_valid returns to 0 the next cycle.
- dig_sel=4'b0010 with seg_in alternating 7'b1111110/7'b1111111 every 2 cycles for 20 cycles -> no capture; dig_valid=0.
- dig_sel=4'b0100, seg_in=7'b1000000 held 8 cycles -> bcd_out[11:8]=4'hF; pat_err=1 and remains set after valid digits follow.
- dig_sel=4'b0011 (invalid), valid pattern held 10 cycles -> no capture. Then rst_n=0 for one edge during SETTLE -> all outputs 0 on the next cycle.
- With SEG7_BLANK_DECODE_EN defined: seg_in=0 on digit 3, held 5 cycles -> bcd_out[15:12]=4'hA; pat_err=0.

Source files
------------

// File: rtl/seg7_scan_capture_if.sv
// rtl/seg7_scan_capture_if.sv - segment bus, digit strobe and captured-digit signals of the 7-seg scan receiver
interface seg7_scan_capture_if #(
    parameter int NUM_DIG = 4
);
    logic [6:0]           seg_in;
    logic [NUM_DIG-1:0]   dig_sel;
    logic [4*NUM_DIG-1:0] bcd_out;
    logic [NUM_DIG-1:0]   dig_valid;
    logic                 frame_done;
    logic                 pat_err;

    // Display side: drives the segment bus and strobes, observes the recovered digits
    modport master (
        output seg_in,
        output dig_sel,
        input  bcd_out,
        input  dig_valid,
        input  frame_done,
        input  pat_err
    );

    // Receiver side
    modport slave (
        input  seg_in,
        input  dig_sel,
        output bcd_out,
        output dig_valid,
        output frame_done,
        output pat_err
    );
endinterface

// File: rtl/seg7_scan_capture.sv
// rtl/seg7_scan_capture.sv - 7-seg scan receiver recovering BCD digits (option: SEG7_BLANK_DECODE_EN)
module seg7_scan_capture #(
    parameter int NUM_DIG    = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    seg7_scan_capture_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam logic [8:0] LP_STABLE = 9'(STABLE_CYC);

    logic [6:0]           r_seg;
    logic [NUM_DIG-1:0]   r_sel;
    logic [6:0]           r_ref_seg;
    logic [NUM_DIG-1:0]   r_ref_sel;
    logic [7:0]           r_cnt;
    state_t               r_state;
    logic [4*NUM_DIG-1:0] r_bcd;
    logic [NUM_DIG-1:0]   r_dig_valid;
    logic                 r_frame_done;
    logic                 r_pat_err;

    logic                 w_sel_valid;
    logic                 w_match;
    logic                 w_stable;
    logic [3:0]           w_dec_val;
    logic                 w_dec_bad;
    logic [NUM_DIG-1:0]   w_cap_mask;
    logic [NUM_DIG-1:0]   w_dv_base;
    logic [NUM_DIG-1:0]   w_dv_next;

    // Sample stage: every decision below is taken on these registered copies
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg <= '0;
            r_sel <= '0;
        end else begin
            r_seg <= bus.seg_in;
            r_sel <= bus.dig_sel;
        end
    end

    // A select is usable only when exactly one strobe bit is high
    always_comb begin
        w_sel_valid = (r_sel != '0) && ((r_sel & (r_sel - 1'b1)) == '0);
        w_match     = (r_seg == r_ref_seg) && (r_sel == r_ref_sel);
        w_stable    = ({1'b0, r_cnt} + 9'd1) >= LP_STABLE;
    end

    // Segment pattern {a..g} to BCD; anything off-table becomes 4'hF and flags an error
    always_comb begin
        w_dec_val = 4'hF;
        w_dec_bad = 1'b0;
        case (r_ref_seg)
            7'b1111110: w_dec_val = 4'd0;
            7'b0110000: w_dec_val = 4'd1;
            7'b1101101: w_dec_val = 4'd2;
            7'b1111001: w_dec_val = 4'd3;
            7'b0110011: w_dec_val = 4'd4;
            7'b1011011: w_dec_val = 4'd5;
            7'b1011111: w_dec_val = 4'd6;
            7'b1110000: w_dec_val = 4'd7;
            7'b1111111: w_dec_val = 4'd8;
            7'b1111011: w_dec_val = 4'd9;
`ifdef SEG7_BLANK_DECODE_EN
            7'b0000000: w_dec_val = 4'hA;
`endif
            default: begin
                w_dec_val = 4'hF;
                w_dec_bad = 1'b1;
            end
        endcase
    end

    // The clear that follows frame_done never hides a capture landing in the same cycle
    always_comb begin
        w_cap_mask = (r_state == CAPTURE) ? r_ref_sel : '0;
        w_dv_base  = r_frame_done ? '0 : r_dig_valid;
        w_dv_next  = w_dv_base | w_cap_mask;
    end

    // Capture FSM with stability counter and registered digit/frame/error outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_ref_seg    <= '0;
            r_ref_sel    <= '0;
            r_cnt        <= '0;
            r_bcd        <= '0;
            r_dig_valid  <= '0;
            r_frame_done <= 1'b0;
            r_pat_err    <= 1'b0;
        end else begin
            r_dig_valid  <= w_dv_next;
            r_frame_done <= (w_dv_next == {NUM_DIG{1'b1}}) && (w_dv_base != {NUM_DIG{1'b1}});

            case (r_state)
                IDLE: begin
                    if (w_sel_valid) begin
                        r_state   <= SETTLE;
                        r_ref_seg <= r_seg;
                        r_ref_sel <= r_sel;
                        r_cnt     <= 8'd1;
                    end
                end
                SETTLE: begin
                    if (w_match) begin
                        r_cnt <= r_cnt + 8'd1;
                        if (w_stable) begin
                            r_state <= CAPTURE;
                        end
                    end else if (!w_sel_valid) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_ref_seg <= r_seg;
                        r_ref_sel <= r_sel;
                        r_cnt     <= 8'd1;
                    end
                end
                CAPTURE: begin
                    for (int k = 0; k < NUM_DIG; k++) begin
                        if (w_cap_mask[k]) begin
                            r_bcd[4*k +: 4] <= w_dec_val;
                        end
                    end
                    if (w_dec_bad) begin
                        r_pat_err <= 1'b1;
                    end
                    r_cnt   <= '0;
                    r_state <= HOLD;
                end
                HOLD: begin
                    if (!w_match) begin
                        if (w_sel_valid) begin
                            r_state   <= SETTLE;
                            r_ref_seg <= r_seg;
                            r_ref_sel <= r_sel;
                            r_cnt     <= 8'd1;
                        end else begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.bcd_out    = r_bcd;
    assign bus.dig_valid  = r_dig_valid;
    assign bus.frame_done = r_frame_done;
    assign bus.pat_err    = r_pat_err;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb/tb_seg7_scan_capture.sv - directed bench for seg7_scan_capture
module tb_seg7_scan_capture;

    localparam int NUM_DIG = 4;

    localparam logic [6:0] P0 = 7'b1111110;
    localparam logic [6:0] P1 = 7'b0110000;
    localparam logic [6:0] P2 = 7'b1101101;
    localparam logic [6:0] P3 = 7'b1111001;
    localparam logic [6:0] P5 = 7'b1011011;
    localparam logic [6:0] P7 = 7'b1110000;
    localparam logic [6:0] P8 = 7'b1111111;
    localparam logic [6:0] P9 = 7'b1111011;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   fd_cnt   = 0;
    int   fd_start;

    always #5 clk = ~clk;

    seg7_scan_capture_if #(.NUM_DIG(NUM_DIG)) bus ();

    seg7_scan_capture #(
        .NUM_DIG   (NUM_DIG),
        .STABLE_CYC(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Count frame_done pulses between edges, clear of the negedge checks
    always @(posedge clk) begin
        #2;
        if (bus.frame_done === 1'b1) fd_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [NUM_DIG-1:0] sel, input logic [6:0] seg);
        bus.dig_sel = sel;
        bus.seg_in  = seg;
    endtask

    logic [NUM_DIG-1:0] scan_sel [4];
    logic [6:0]         scan_seg [4];

    initial begin
        scan_sel[0] = 4'b0001; scan_seg[0] = P2;
        scan_sel[1] = 4'b0010; scan_seg[1] = P0;
        scan_sel[2] = 4'b0100; scan_seg[2] = P2;
        scan_sel[3] = 4'b1000; scan_seg[3] = P5;

        rst_n = 1'b0;
        drive('0, '0);
        tick(3);
        check_eq("rst_bcd", 32'(bus.bcd_out), 32'h0);
        check_eq("rst_dv", 32'(bus.dig_valid), 32'h0);
        check_eq("rst_fd", 32'(bus.frame_done), 32'h0);
        check_eq("rst_pe", 32'(bus.pat_err), 32'h0);

        // Single digit: first sample edge + IDLE + 3 SETTLE edges, written on the 6th edge
        rst_n = 1'b1;
        drive(4'b0001, P1);
        tick(5);
        check_eq("lat_before", 32'(bus.bcd_out), 32'h0);
        tick(1);
        check_eq("lat_at", 32'(bus.bcd_out[3:0]), 32'h1);
        check_eq("lat_dv", 32'(bus.dig_valid), 32'h1);
        tick(4);
        check_eq("d1_bcd", 32'(bus.bcd_out), 32'h0001);
        check_eq("d1_pe", 32'(bus.pat_err), 32'h0);

        // Full scan 2,0,2,5
        fd_start = fd_cnt;
        for (int i = 0; i < 3; i++) begin
            drive(scan_sel[i], scan_seg[i]);
            tick(6);
        end
        check_eq("scan_dv3", 32'(bus.dig_valid), 32'h7);
        check_eq("scan_fd_early", 32'(bus.frame_done), 32'h0);
        drive(scan_sel[3], scan_seg[3]);
        tick(6);
        check_eq("scan_bcd", 32'(bus.bcd_out), 32'h5202);
        check_eq("scan_fd", 32'(bus.frame_done), 32'h1);
        check_eq("scan_dv_all", 32'(bus.dig_valid), 32'hF);
        tick(1);
        check_eq("scan_fd_off", 32'(bus.frame_done), 32'h0);
        check_eq("scan_dv_clr", 32'(bus.dig_valid), 32'h0);
        check_eq("scan_bcd_keep", 32'(bus.bcd_out), 32'h5202);
        check_eq("scan_fd_cnt", 32'(fd_cnt - fd_start), 32'd1);

        // Glitching pattern never stable long enough
        for (int i = 0; i < 10; i++) begin
            drive(4'b0010, (i % 2 == 1) ? P8 : P0);
            tick(2);
        end
        check_eq("glitch_dv", 32'(bus.dig_valid), 32'h0);
        check_eq("glitch_bcd", 32'(bus.bcd_out), 32'h5202);
        check_eq("glitch_pe", 32'(bus.pat_err), 32'h0);

        // Off-table pattern, then a valid digit: error is sticky
        drive(4'b0100, 7'b1000000);
        tick(8);
        check_eq("bad_bcd", 32'(bus.bcd_out), 32'h5F02);
        check_eq("bad_pe", 32'(bus.pat_err), 32'h1);
        check_eq("bad_dv", 32'(bus.dig_valid), 32'h4);
        drive(4'b0001, P7);
        tick(8);
        check_eq("after_bad_bcd", 32'(bus.bcd_out), 32'h5F07);
        check_eq("after_bad_pe", 32'(bus.pat_err), 32'h1);
        check_eq("after_bad_dv", 32'(bus.dig_valid), 32'h5);

        // Two strobe bits: ignored
        drive(4'b0011, P3);
        tick(10);
        check_eq("multi_bcd", 32'(bus.bcd_out), 32'h5F07);
        check_eq("multi_dv", 32'(bus.dig_valid), 32'h5);

        // Reset in the middle of SETTLE
        drive(4'b0010, P9);
        tick(3);
        rst_n = 1'b0;
        drive('0, '0);
        tick(1);
        check_eq("mid_rst_bcd", 32'(bus.bcd_out), 32'h0);
        check_eq("mid_rst_dv", 32'(bus.dig_valid), 32'h0);
        check_eq("mid_rst_pe", 32'(bus.pat_err), 32'h0);
        check_eq("mid_rst_fd", 32'(bus.frame_done), 32'h0);

        // All-zero pattern on digit 3
        rst_n = 1'b1;
        drive(4'b1000, 7'b0000000);
        tick(7);
`ifdef SEG7_BLANK_DECODE_EN
        check_eq("blank_bcd", 32'(bus.bcd_out[15:12]), 32'hA);
        check_eq("blank_pe", 32'(bus.pat_err), 32'h0);
`else
        check_eq("blank_bcd", 32'(bus.bcd_out[15:12]), 32'hF);
        check_eq("blank_pe", 32'(bus.pat_err), 32'h1);
`endif
        check_eq("blank_dv", 32'(bus.dig_valid), 32'h8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
